// File: rtl/change_payout_pkg.sv
`default_nettype none
// =============================================================================
// payout_pkg : FSM states and coin denomination codes for change_payout
// Rev 1.0
// =============================================================================
package payout_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PICK     = 3'd1,
      EJECT    = 3'd2,
      WAIT_ACK = 3'd3,
      DONE     = 3'd4
   } state_t;

   // Same encoding as the vending coin bus so refill_sel maps directly.
   localparam logic [1:0] DEN_NONE = 2'b00;
   localparam logic [1:0] DEN_1    = 2'b01;
   localparam logic [1:0] DEN_2    = 2'b10;
   localparam logic [1:0] DEN_5    = 2'b11;

   localparam int VAL_1 = 1;
   localparam int VAL_2 = 2;
   localparam int VAL_5 = 5;

   function automatic logic [2:0] den_value(input logic [1:0] den);
      case (den)
         DEN_1:   return 3'(VAL_1);
         DEN_2:   return 3'(VAL_2);
         DEN_5:   return 3'(VAL_5);
         default: return 3'd0;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/change_payout_coin_inv_counter.sv
`default_nettype none
// =============================================================================
// coin_inv_counter : per-denomination coin inventory, saturating refill, debit
// Rev 1.0
// =============================================================================
module coin_inv_counter #(
   parameter int CNT_W = 6,
   parameter int INIT  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             add,
   input  logic [CNT_W-1:0] add_cnt,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             nonzero
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W:0]   w_sum;

   assign w_sum = {1'b0, r_count} + {1'b0, add_cnt};

   // add and dec come from mutually exclusive FSM states, so priority is moot.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_count <= CNT_W'(INIT);
      end else if (add) begin
         r_count <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
      end else if (dec) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign count   = r_count;
   assign nonzero = |r_count;

endmodule
`default_nettype wire

// File: rtl/change_payout.sv
`default_nettype none
// =============================================================================
// change_payout : greedy Rs5/Rs2/Rs1 coin-hopper payout controller
// Rev 1.0
// =============================================================================
module change_payout
   import payout_pkg::*;
#(
   parameter int AMT_W     = 4,
   parameter int CNT_W     = 6,
   parameter int INIT_5    = 8,
   parameter int INIT_2    = 8,
   parameter int INIT_1    = 8,
   parameter int PULSE_CYC = 2,
   parameter int ACK_TMO   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
   input  logic             hop_ack,
   input  logic             refill,
   input  logic [1:0]       refill_sel,
   input  logic [CNT_W-1:0] refill_cnt,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] owed,
   output logic             eject_5,
   output logic             eject_2,
   output logic             eject_1,
   output logic [CNT_W-1:0] inv_5,
   output logic [CNT_W-1:0] inv_2,
   output logic [CNT_W-1:0] inv_1
);

   localparam int              c_PW         = $clog2(PULSE_CYC + 1);
   localparam int              c_TW         = $clog2(ACK_TMO + 1);
   localparam logic [c_PW-1:0] c_PULSE_LAST = c_PW'(PULSE_CYC - 1);
   localparam logic [c_TW-1:0] c_TMO_LAST   = c_TW'(ACK_TMO - 1);
   localparam logic [AMT_W-1:0] c_V5        = AMT_W'(VAL_5);
   localparam logic [AMT_W-1:0] c_V2        = AMT_W'(VAL_2);
   localparam logic [AMT_W-1:0] c_V1        = AMT_W'(VAL_1);

   state_t           r_state, w_state_nxt;
   logic [AMT_W-1:0] r_rem, w_rem_nxt;
   logic [1:0]       r_den, w_den_nxt;
   logic [c_PW-1:0]  r_pcnt, w_pcnt_nxt;
   logic [c_TW-1:0]  r_tcnt, w_tcnt_nxt;
   logic             r_short, w_short_nxt;
   logic [AMT_W-1:0] r_owed, w_owed_nxt;
   logic [1:0]       w_pick_den;
   logic [AMT_W-1:0] w_den_val;
   logic             w_nz_5, w_nz_2, w_nz_1;
   logic             w_idle, w_debit;

   assign w_idle    = (r_state == IDLE);
   assign w_debit   = (r_state == WAIT_ACK) && hop_ack;
   assign w_den_val = AMT_W'(den_value(r_den));

   // Greedy choice, no backtracking once a larger coin has been paid.
   always_comb begin
      w_pick_den = DEN_NONE;
      if (r_rem >= c_V5 && w_nz_5) begin
         w_pick_den = DEN_5;
      end else if (r_rem >= c_V2 && w_nz_2) begin
         w_pick_den = DEN_2;
      end else if (r_rem >= c_V1 && w_nz_1) begin
         w_pick_den = DEN_1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_den_nxt   = r_den;
      w_pcnt_nxt  = r_pcnt;
      w_tcnt_nxt  = r_tcnt;
      w_short_nxt = r_short;
      w_owed_nxt  = r_owed;
      case (r_state)
         IDLE: begin
            if (req) begin
               w_rem_nxt   = amount;
               w_short_nxt = 1'b0;
               w_owed_nxt  = '0;
               w_state_nxt = PICK;
            end
         end
         PICK: begin
            if (r_rem == '0) begin
               w_state_nxt = DONE;
            end else if (w_pick_den != DEN_NONE) begin
               w_den_nxt   = w_pick_den;
               w_pcnt_nxt  = '0;
               w_state_nxt = EJECT;
            end else begin
               w_short_nxt = 1'b1;
               w_owed_nxt  = r_rem;
               w_state_nxt = DONE;
            end
         end
         EJECT: begin
            if (r_pcnt == c_PULSE_LAST) begin
               w_tcnt_nxt  = '0;
               w_state_nxt = WAIT_ACK;
            end else begin
               w_pcnt_nxt = r_pcnt + c_PW'(1);
            end
         end
         WAIT_ACK: begin
            if (hop_ack) begin
               w_rem_nxt   = r_rem - w_den_val;
               w_state_nxt = PICK;
            end else if (r_tcnt == c_TMO_LAST) begin
               w_short_nxt = 1'b1;
               w_owed_nxt  = r_rem;
               w_state_nxt = DONE;
            end else begin
               w_tcnt_nxt = r_tcnt + c_TW'(1);
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_rem   <= '0;
         r_den   <= DEN_NONE;
         r_pcnt  <= '0;
         r_tcnt  <= '0;
         r_short <= 1'b0;
         r_owed  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_den   <= w_den_nxt;
         r_pcnt  <= w_pcnt_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_short <= w_short_nxt;
         r_owed  <= w_owed_nxt;
      end
   end

   coin_inv_counter #(.CNT_W(CNT_W), .INIT(INIT_5)) u_inv_5 (
      .clk     (clk),
      .reset_n (reset_n),
      .add     (w_idle && refill && (refill_sel == DEN_5)),
      .add_cnt (refill_cnt),
      .dec     (w_debit && (r_den == DEN_5)),
      .count   (inv_5),
      .nonzero (w_nz_5)
   );

   coin_inv_counter #(.CNT_W(CNT_W), .INIT(INIT_2)) u_inv_2 (
      .clk     (clk),
      .reset_n (reset_n),
      .add     (w_idle && refill && (refill_sel == DEN_2)),
      .add_cnt (refill_cnt),
      .dec     (w_debit && (r_den == DEN_2)),
      .count   (inv_2),
      .nonzero (w_nz_2)
   );

   coin_inv_counter #(.CNT_W(CNT_W), .INIT(INIT_1)) u_inv_1 (
      .clk     (clk),
      .reset_n (reset_n),
      .add     (w_idle && refill && (refill_sel == DEN_1)),
      .add_cnt (refill_cnt),
      .dec     (w_debit && (r_den == DEN_1)),
      .count   (inv_1),
      .nonzero (w_nz_1)
   );

   assign busy    = !w_idle;
   assign done    = (r_state == DONE);
   assign short   = r_short;
   assign owed    = r_owed;
   assign eject_5 = (r_state == EJECT) && (r_den == DEN_5);
   assign eject_2 = (r_state == EJECT) && (r_den == DEN_2);
   assign eject_1 = (r_state == EJECT) && (r_den == DEN_1);

endmodule
`default_nettype wire
